// File: rtl/comparator_hyst_bank.sv
// Multi-channel IEEE-754 single comparator bank with per-channel hysteresis, one channel per clock.
// Optional macro COMPARATOR_NAN_FLAG_EN adds a per-channel nan_flag output.
module comparator_hyst_bank #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int CH_BITS  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sta,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0]          upper_th,
  input  logic [WIDTH-1:0]          lower_th,
  output logic [CHANNELS-1:0]       agb,
  output logic [CHANNELS-1:0]       alb,
  output logic [CHANNELS-1:0]       hyst_out,
  output logic                      busy,
  output logic                      done_sig
`ifdef COMPARATOR_NAN_FLAG_EN
  ,
  output logic [CHANNELS-1:0]       nan_flag
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0]   SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CH_BITS-1:0] LAST_CH  = CH_BITS'(CHANNELS - 1);

  logic [1:0]                state;
  logic [CH_BITS-1:0]        ch;
  logic [CHANNELS*WIDTH-1:0] data_p0;
  logic [WIDTH-1:0]          upper_p0;
  logic [WIDTH-1:0]          lower_p0;
  logic [WIDTH-1:0]          samp;
  logic                      gt_c;
  logic                      lt_c;
  logic                      nan_c;

  function automatic logic is_nan(input logic [WIDTH-1:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

  // Map a float onto an unsigned key whose integer order matches float order; -0 folds onto +0.
  function automatic logic [WIDTH-1:0] ord_key(input logic [WIDTH-1:0] f);
    if (f[WIDTH-2:0] == '0) return SIGN_BIT;
    else if (f[WIDTH-1])    return ~f;
    else                    return f | SIGN_BIT;
  endfunction

  function automatic logic f_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (is_nan(a) || is_nan(b)) return 1'b0;
    return ord_key(a) > ord_key(b);
  endfunction

  always_comb begin
    samp = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch == CH_BITS'(k)) samp = data_p0[k*WIDTH +: WIDTH];
    end
    gt_c  = f_gt(samp, upper_p0);
    lt_c  = f_gt(lower_p0, samp);
    nan_c = is_nan(samp) || is_nan(upper_p0) || is_nan(lower_p0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ch       <= '0;
      data_p0  <= '0;
      upper_p0 <= '0;
      lower_p0 <= '0;
      agb      <= '0;
      alb      <= '0;
      hyst_out <= '0;
      busy     <= 1'b0;
      done_sig <= 1'b0;
`ifdef COMPARATOR_NAN_FLAG_EN
      nan_flag <= '0;
`endif
    end else begin
      done_sig <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (sta && !done_sig) begin
            data_p0  <= data_in;
            upper_p0 <= upper_th;
            lower_p0 <= lower_th;
            ch       <= '0;
            busy     <= 1'b1;
            state    <= RUN;
`ifdef COMPARATOR_NAN_FLAG_EN
            nan_flag <= '0;
`endif
          end
        end
        RUN: begin
          for (int k = 0; k < CHANNELS; k++) begin
            if (ch == CH_BITS'(k)) begin
              agb[k] <= gt_c;
              alb[k] <= lt_c;
              if (gt_c)      hyst_out[k] <= 1'b1;
              else if (lt_c) hyst_out[k] <= 1'b0;
`ifdef COMPARATOR_NAN_FLAG_EN
              nan_flag[k] <= nan_c;
`endif
            end
          end
          if (ch == LAST_CH) state <= DONE;
          else               ch    <= ch + 1'b1;
        end
        DONE: begin
          done_sig <= 1'b1;
          busy     <= 1'b0;
          ch       <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef COMPARATOR_NAN_FLAG_EN
  logic unused_nan;
  assign unused_nan = nan_c;
`endif

endmodule

// File: tb/tb_comparator_hyst_bank.sv
// Directed bench for comparator_hyst_bank with a queue-based scoreboard of expected result vectors.
module tb_comparator_hyst_bank;

  localparam int W = 32;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           sta;
  logic [C*W-1:0] data_in;
  logic [W-1:0]   upper_th;
  logic [W-1:0]   lower_th;
  logic [C-1:0]   agb;
  logic [C-1:0]   alb;
  logic [C-1:0]   hyst_out;
  logic           busy;
  logic           done_sig;
`ifdef COMPARATOR_NAN_FLAG_EN
  logic [C-1:0]   nan_flag;
`endif

  comparator_hyst_bank #(.WIDTH(W), .CHANNELS(C), .CH_BITS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .sta      (sta),
    .data_in  (data_in),
    .upper_th (upper_th),
    .lower_th (lower_th),
    .agb      (agb),
    .alb      (alb),
    .hyst_out (hyst_out),
    .busy     (busy),
    .done_sig (done_sig)
`ifdef COMPARATOR_NAN_FLAG_EN
    ,
    .nan_flag (nan_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [C-1:0] agb;
    logic [C-1:0] alb;
    logic [C-1:0] hyst;
    logic [C-1:0] nan;
  } exp_t;

  exp_t         sb_q[$];
  logic [C-1:0] hyst_m;
  int           n_pass = 0;
  int           n_total = 0;
  int           n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 0);
  endfunction

  // Reference ordering by sign/magnitude case analysis.
  function automatic bit m_gt(input logic [31:0] a, input logic [31:0] b);
    if (m_nan(a) || m_nan(b)) return 1'b0;
    if (a[30:0] == 0 && b[30:0] == 0) return 1'b0;
    if (a[31] != b[31]) return b[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  task automatic start_run(input logic [C*W-1:0] d, input logic [W-1:0] up, input logic [W-1:0] lo,
                           input string tag, input bit extra_sta);
    exp_t e;
    int   cnt;
    for (int k = 0; k < C; k++) begin
      logic [31:0] v;
      v = d[k*W +: W];
      e.agb[k] = m_gt(v, up);
      e.alb[k] = m_gt(lo, v);
      e.nan[k] = m_nan(v) || m_nan(up) || m_nan(lo);
      if (e.agb[k])      hyst_m[k] = 1'b1;
      else if (e.alb[k]) hyst_m[k] = 1'b0;
    end
    e.hyst = hyst_m;
    sb_q.push_back(e);
    data_in = d; upper_th = up; lower_th = lo; sta = 1'b1;
    @(negedge clk);
    sta = 1'b0;
    data_in = {$urandom, $urandom, $urandom, $urandom};
    upper_th = $urandom; lower_th = $urandom;
    check({tag, "_busy_run"}, busy, 1);
    cnt = 0;
    while (!done_sig && cnt < 20) begin
      @(negedge clk);
      cnt++;
      sta = extra_sta && (cnt == 2);
      if (extra_sta && cnt == 3) check({tag, "_busy_ign"}, busy, 1);
    end
    check({tag, "_latency"}, cnt, 5);
    if (sb_q.size() == 0) check({tag, "_sb_empty"}, 0, 1);
    else begin
      e = sb_q.pop_front();
      check({tag, "_agb"}, agb, e.agb);
      check({tag, "_alb"}, alb, e.alb);
      check({tag, "_hyst"}, hyst_out, e.hyst);
`ifdef COMPARATOR_NAN_FLAG_EN
      check({tag, "_nan"}, nan_flag, e.nan);
`endif
    end
    sta = extra_sta;
    @(negedge clk);
    sta = 1'b0;
    check({tag, "_done_1cyc"}, done_sig, 0);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  localparam logic [31:0] N1  = 32'hBF800000;
  localparam logic [31:0] P05 = 32'h3F000000;
  localparam logic [31:0] P2  = 32'h40000000;
  localparam logic [31:0] P1  = 32'h3F800000;

  initial begin
    rst = 1'b0; sta = 1'b0; data_in = '0; upper_th = '0; lower_th = '0; hyst_m = '0;
    repeat (2) @(negedge clk);
    check("rst_agb", agb, 0);
    check("rst_alb", alb, 0);
    check("rst_hyst", hyst_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_sig, 0);
    rst = 1'b1;
    @(negedge clk);

    start_run({N1, P05, P2, P1}, P1, P05, "t1", 1'b0);
    check("t1_agb_c", agb, 4'b0010);
    check("t1_alb_c", alb, 4'b1000);
    check("t1_hyst_c", hyst_out, 4'b0010);

    start_run({N1, P05, P2, P2}, P1, P05, "t2a", 1'b0);
    check("t2a_hyst0", hyst_out[0], 1);
    start_run({N1, P05, P2, 32'h3F400000}, P1, P05, "t2b", 1'b0);
    check("t2b_agb0", agb[0], 0);
    check("t2b_alb0", alb[0], 0);
    check("t2b_hyst0", hyst_out[0], 1);
    start_run({N1, P05, P2, 32'h3E800000}, P1, P05, "t2c", 1'b0);
    check("t2c_hyst0", hyst_out[0], 0);

    start_run({N1, P05, P2, 32'h80000000}, 32'h0, 32'h0, "t3a", 1'b0);
    check("t3a_agb0", agb[0], 0);
    check("t3a_alb0", alb[0], 0);
    start_run({N1, P05, P2, 32'h80000001}, 32'h0, 32'h0, "t3b", 1'b0);
    check("t3b_alb0", alb[0], 1);
    check("t3b_hyst1", hyst_out[1], 1);

    start_run({N1, P05, 32'h7FC00000, P1}, P1, P05, "t4", 1'b0);
    check("t4_agb1", agb[1], 0);
    check("t4_alb1", alb[1], 0);
    check("t4_hyst1", hyst_out[1], 1);
`ifdef COMPARATOR_NAN_FLAG_EN
    check("t4_nanflag1", nan_flag[1], 1);
`endif

    start_run({P2, 32'hFF800000, 32'h7F800000, P05}, P1, P05, "t5a", 1'b1);
    start_run({N1, P05, P2, P1}, P1, P05, "t5b", 1'b0);

    data_in = {P2, P2, P2, P2}; upper_th = P1; lower_th = P05; sta = 1'b1;
    @(negedge clk);
    sta = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_agb", agb, 0);
    check("t6_alb", alb, 0);
    check("t6_hyst", hyst_out, 0);
    check("t6_busy", busy, 0);
    hyst_m = '0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (done_sig) seen++;
      end
      check("t6_no_done", seen, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    start_run({P05, N1, P2, P1}, P1, P05, "t6b", 1'b0);
    check("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/comparator_hyst_bank.md
Name: comparator_hyst_bank

Overview:
Multi-channel IEEE-754 single-precision comparator bank with per-channel hysteresis, for the control-system datapath. On a start pulse it latches CHANNELS packed float samples and a shared upper/lower threshold pair. It then compares one channel per clock, updating greater/less flags and a hysteresis state bit per channel. done_sig pulses once the whole vector is valid. It succeeds the single-pair comparator and needs no vendor compare IP; the compare logic is native RTL.

Parameters:
WIDTH, 32, float word width; only 32 (IEEE-754 single) is supported.
CHANNELS, 4, number of compared channels; legal range 1..64.
CH_BITS, 2, channel counter width; must satisfy 2^CH_BITS >= CHANNELS.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
sta  input  1  start pulse; sampled only in IDLE
data_in  input  CHANNELS*WIDTH  packed samples; channel k is bits [k*WIDTH +: WIDTH]
upper_th  input  WIDTH  set threshold
lower_th  input  WIDTH  clear threshold
agb  output  CHANNELS  channel value > upper_th
alb  output  CHANNELS  channel value < lower_th
hyst_out  output  CHANNELS  hysteresis state per channel
busy  output  1  high from the cycle after sta acceptance until done_sig
done_sig  output  1  one-cycle pulse when all outputs are valid

Behaviour:
- Reset (rst=0, async): FSM=IDLE, channel counter=0, and agb, alb, hyst_out, busy, done_sig, and all latched data cleared to 0.
- FSM states are IDLE, RUN, DONE.
- IDLE: if sta=1 at edge E0, latch data_in, upper_th and lower_th; set ch=0, busy=1, and go to RUN. If sta=0, stay.
- RUN: at edge E(k+1), register the compare results for channel k into agb[k], alb[k] and hyst_out[k]. Increment ch. At ch==CHANNELS-1, go to DONE.
- DONE: at edge E(CHANNELS+1), done_sig=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: done_sig is high CHANNELS+1 cycles after sta is accepted. With CHANNELS=4, that is 5 cycles.
- Next start: a sta asserted in the same cycle as done_sig is ignored. A new start may be accepted at the earliest on the edge after done_sig falls.
- sta while RUN or DONE is ignored, with no queueing. Inputs changing after acceptance have no effect.
- Channel k outputs update only at their own edge. Outputs for other channels hold their previous run's values until rewritten.
- Float compare (combinational, sign-magnitude):
  - +0 and -0 are equal.
  - Negatives are ordered by inverted magnitude.
  - Denormals are compared as ordinary magnitudes.
  - +/-Inf are ordered normally.
  - NaN (exp=0xFF, mantissa!=0) in the value or the relevant threshold makes that flag 0.
- Hysteresis: if agb[k]=1 then hyst_out[k]=1; else if alb[k]=1 then hyst_out[k]=0; else hyst_out[k] holds.
  - Set has priority, so a value above upper and below lower (because lower_th > upper_th) gives 1.
  - A NaN value leaves hyst_out[k] unchanged.
- Reset mid-run: everything clears immediately and no done_sig is issued.

Optional Feature:
Macro COMPARATOR_NAN_FLAG_EN.
- Defined: adds output port nan_flag [CHANNELS-1:0]. Bit k is set at channel k's compare edge when the value or either threshold is NaN. All bits clear when sta is accepted and on reset.
- Undefined: port absent and no logic. NaN is handled only through the flag rule above.

Test Plan:
1. Reset, then sta with CHANNELS=4, data={-1.0 BF800000, 0.5 3F000000, 2.0 40000000, 1.0 3F800000} (ch3..ch0), upper=3F800000, lower=3F000000 -> done_sig high exactly 5 cycles after sta; agb=0010, alb=1000, hyst_out=0010.
2. Repeat with ch0=0x3F400000 (0.75) after hyst_out[0] was set by ch0=0x40000000 -> agb[0]=0, alb[0]=0, hyst_out[0] holds 1. Then ch0=0x3E800000 (0.25) -> hyst_out[0]=0.
3. upper=0x00000000, lower=0x00000000, ch0=0x80000000 (-0) -> agb[0]=0, alb[0]=0. Then ch0=0x80000001 -> alb[0]=1.
4. ch1=0x7FC00000 (NaN) with hyst_out[1]=1 -> agb[1]=alb[1]=0, hyst_out[1]=1; nan_flag[1]=1 when COMPARATOR_NAN_FLAG_EN is defined.
5. sta re-pulsed during RUN and in the done_sig cycle -> ignored, busy unchanged, single done_sig. Back-to-back sta one cycle after done_sig -> accepted.
6. Assert rst at the 2nd RUN cycle -> all outputs 0 asynchronously, no done_sig. After release, a new sta completes normally.
